fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the single write port of `sync_fifo` between `NREQ` producers. Each producer raises a request and presents a data word. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `w_enable` and `w_data`. It stalls on `full` without dropping or duplicating words. The block sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port between NREQ producers.
// Grants one requester at a time for up to MAX_BURST words and stalls on fifo_full.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DW-1:0]        wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           ack,
    output logic                      fifo_w_enable,
    output logic [DW-1:0]             fifo_w_data,
    input  logic                      fifo_full,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [OW-1:0] last;
    logic [OW-1:0] base;
    logic [OW-1:0] win;
    logic          found;
    logic [CW-1:0] cnt;
    logic          xfer;
    logic          rel;

    // Writes are held off while reset is asserted so an aborted burst leaves no stray word.
    always_comb begin
        xfer          = reset && (state == GRANT) && gnt[owner] && req[owner] && !fifo_full;
        fifo_w_enable = xfer;
        fifo_w_data   = wdata[int'(owner)*DW +: DW];
        ack           = '0;
        ack[owner]    = xfer;
        rel           = (state == GRANT) && ((xfer && (cnt == CNT_MAX)) || !req[owner]);
    end

    // On release the current owner becomes "last", so it is checked last in the search.
    always_comb begin
        base  = (state == GRANT) ? owner : last;
        found = 1'b0;
        win   = base;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[(int'(base) + i) % NREQ]) begin
                found = 1'b1;
                win   = OW'((int'(base) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            last  <= OW'(NREQ - 1);
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= NREQ'(1) << win;
                        owner <= win;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        last <= owner;
                        if (found) begin
                            gnt   <= NREQ'(1) << win;
                            owner <= win;
                            cnt   <= '0;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter (NREQ=4, DW=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        fifo_w_enable;
    logic [7:0]  fifo_w_data;
    logic        fifo_full;
    logic [1:0]  owner;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .gnt(gnt), .ack(ack),
        .fifo_w_enable(fifo_w_enable), .fifo_w_data(fifo_w_data),
        .fifo_full(fifo_full), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rn;
        logic [3:0]  req;
        logic [31:0] wd;
        bit          full;
        logic [3:0]  gnt;
        bit          we;
        logic [7:0]  wdo;
        logic [1:0]  own;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rn, input logic [3:0] r, input logic [31:0] wd, input bit full,
                       input logic [3:0] g, input bit we, input logic [7:0] wdo, input logic [1:0] own);
        vec_t v;
        v.rn = rn; v.req = r; v.wd = wd; v.full = full;
        v.gnt = g; v.we = we; v.wdo = wdo; v.own = own;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected ack is the grant when a write happens, else zero; busy tracks |gnt.
    task automatic chk_out(input string tag, input logic [3:0] g, input bit we,
                           input logic [7:0] wdo, input logic [1:0] own);
        chk({tag, ".gnt"},   32'(gnt), 32'(g));
        chk({tag, ".we"},    32'(fifo_w_enable), 32'(we));
        chk({tag, ".ack"},   32'(ack), 32'(we ? g : 4'b0000));
        chk({tag, ".busy"},  32'(busy), 32'(|g));
        chk({tag, ".owner"}, 32'(owner), 32'(own));
        if (we) chk({tag, ".wdata"}, 32'(fifo_w_data), 32'(wdo));
    endtask

    task automatic cyc(input bit rn, input logic [3:0] r, input logic [31:0] wd, input bit full);
        @(posedge clk);
        #1;
        reset = rn; req = r; wdata = wd; fifo_full = full;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; req = '0; wdata = '0; fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_out("reset", 4'b0000, 1'b0, 8'h00, 2'd0);

        // single requester: burst limit re-grants with no bubble, then withdraws
        add(1, 4'b0001, 32'h01, 0, 4'b0000, 0, 8'h00, 0);
        add(1, 4'b0001, 32'h01, 0, 4'b0001, 1, 8'h01, 0);
        add(1, 4'b0001, 32'h02, 0, 4'b0001, 1, 8'h02, 0);
        add(1, 4'b0001, 32'h03, 0, 4'b0001, 1, 8'h03, 0);
        add(1, 4'b0001, 32'h04, 0, 4'b0001, 1, 8'h04, 0);
        add(1, 4'b0001, 32'h05, 0, 4'b0001, 1, 8'h05, 0);
        add(1, 4'b0001, 32'h06, 0, 4'b0001, 1, 8'h06, 0);
        add(1, 4'b0000, 32'h07, 0, 4'b0001, 0, 8'h00, 0);
        add(1, 4'b0000, 32'h07, 0, 4'b0000, 0, 8'h00, 0);
        // reset, then round robin 0,1,2,3,0 with 4 words each
        add(0, 4'b0000, 32'h0,  0, 4'b0000, 0, 8'h00, 0);
        add(1, 4'b1111, 32'hD3C2B1A0, 0, 4'b0000, 0, 8'h00, 0);
        for (int i = 0; i < 20; i++)
            add(1, 4'b1111, 32'hD3C2B1A0, 0, 4'(1 << (i / 4 % 4)), 1,
                8'(32'hD3C2B1A0 >> (8 * (i / 4 % 4))), 2'(i / 4 % 4));
        // early withdrawal: 1 drops -> 2 granted, 2 drops after one word -> 3 granted
        add(1, 4'b1100, 32'h00000000, 0, 4'b0010, 0, 8'h00, 1);
        add(1, 4'b1100, 32'h00220000, 0, 4'b0100, 1, 8'h22, 2);
        add(1, 4'b1000, 32'h33000000, 0, 4'b0100, 0, 8'h00, 2);
        add(1, 4'b1000, 32'h33000000, 0, 4'b1000, 1, 8'h33, 3);
        add(1, 4'b1000, 32'h34000000, 0, 4'b1000, 1, 8'h34, 3);
        // full stall at cnt=2: grant held, then exactly 2 words before release to 0
        add(1, 4'b1000, 32'h35000000, 1, 4'b1000, 0, 8'h00, 3);
        add(1, 4'b1000, 32'h35000000, 1, 4'b1000, 0, 8'h00, 3);
        add(1, 4'b1001, 32'h35000040, 1, 4'b1000, 0, 8'h00, 3);
        add(1, 4'b1001, 32'h35000040, 0, 4'b1000, 1, 8'h35, 3);
        add(1, 4'b1001, 32'h36000040, 0, 4'b1000, 1, 8'h36, 3);
        add(1, 4'b1001, 32'h37000040, 0, 4'b0001, 1, 8'h40, 0);
        // reset during requester 1's second word; next grant goes to 0
        add(1, 4'b0010, 32'h00005100, 0, 4'b0001, 0, 8'h00, 0);
        add(1, 4'b0011, 32'h00005140, 0, 4'b0010, 1, 8'h51, 1);
        add(0, 4'b0011, 32'h00005240, 0, 4'b0010, 0, 8'h00, 1);
        add(1, 4'b0011, 32'h00005240, 0, 4'b0000, 0, 8'h00, 0);
        add(1, 4'b0011, 32'h00005240, 0, 4'b0001, 1, 8'h40, 0);
        // owner withdraws while full with nothing else pending -> IDLE
        add(1, 4'b0001, 32'h00000040, 1, 4'b0001, 0, 8'h00, 0);
        add(1, 4'b0000, 32'h00000040, 1, 4'b0001, 0, 8'h00, 0);
        add(1, 4'b0000, 32'h00000040, 1, 4'b0000, 0, 8'h00, 0);
        add(1, 4'b0000, 32'h00000040, 0, 4'b0000, 0, 8'h00, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].rn, tbl[k].req, tbl[k].wd, tbl[k].full);
            chk_out($sformatf("vec%0d", k), tbl[k].gnt, tbl[k].we, tbl[k].wdo, tbl[k].own);
        end

        // grant taken from IDLE while full: held with no write until full clears
        cyc(1, 4'b0100, 32'h00770000, 1);
        chk_out("g_sample", 4'b0000, 1'b0, 8'h00, 2'd0);
        cyc(1, 4'b0100, 32'h00770000, 1);
        chk_out("g_full", 4'b0100, 1'b0, 8'h00, 2'd2);
        cyc(1, 4'b0100, 32'h00770000, 0);
        chk_out("g_write", 4'b0100, 1'b1, 8'h77, 2'd2);
        cyc(1, 4'b0000, 32'h00780000, 0);
        chk_out("g_drop", 4'b0100, 1'b0, 8'h00, 2'd2);
        cyc(1, 4'b0000, 32'h00780000, 0);
        chk_out("g_idle", 4'b0000, 1'b0, 8'h00, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
